// File: rtl/std_div_pkg.sv
// Shared types and helpers for the sequential divider (std_div_seq).
package std_div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    // Bits needed to hold an iteration count from 0 up to w inclusive.
    function automatic int unsigned count_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/std_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module std_div_step
    import std_div_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] rem,
    input  logic             dvd_msb,
    input  logic [width-1:0] divisor,
    output logic [width-1:0] rem_next,
    output logic             q_bit
);

    logic [width:0] shifted;
    logic [width:0] diff;

    // The shifted remainder keeps its top bit so divisors above 2^(width-1) stay exact.
    always_comb begin
        shifted  = {rem, dvd_msb};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[width];
        rem_next = q_bit ? diff[width-1:0] : shifted[width-1:0];
    end

endmodule

// File: rtl/std_div_seq.sv
// Multi-cycle restoring divider with go/done handshake, one quotient bit per cycle.
// Define STD_DIV_SIGNED_EN for two's-complement operands (sign applied around the unsigned core).
module std_div_seq
    import std_div_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done
);

    localparam int unsigned CW = count_width(width);

    div_state_t       state, state_next;
    logic [width-1:0] dvd, dvs, rem, rem_step;
    logic             q_bit;
    logic [CW-1:0]    count;
    logic [width-1:0] left_mag, right_mag;
    logic [width-1:0] q_final, r_final;

`ifdef STD_DIV_SIGNED_EN
    logic neg_q, neg_r;

    always_comb begin
        left_mag  = left[width-1]  ? -left  : left;
        right_mag = right[width-1] ? -right : right;
        q_final   = neg_q ? -{dvd[width-2:0], q_bit} : {dvd[width-2:0], q_bit};
        r_final   = neg_r ? -rem_step : rem_step;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && go) begin
            neg_q <= left[width-1] ^ right[width-1];
            neg_r <= left[width-1];
        end
    end
`else
    always_comb begin
        left_mag  = left;
        right_mag = right;
        q_final   = {dvd[width-2:0], q_bit};
        r_final   = rem_step;
    end
`endif

    std_div_step #(.width(width)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[width-1]),
        .divisor  (dvs),
        .rem_next (rem_step),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = (right == '0) ? DONE : BUSY;
            BUSY:    if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign done = (state == DONE);

    // Quotient bits shift into the dividend register as its bits are consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd           <= '0;
            dvs           <= '0;
            rem           <= '0;
            count         <= '0;
            out_quotient  <= '0;
            out_remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        dvd   <= left_mag;
                        dvs   <= right_mag;
                        rem   <= '0;
                        count <= CW'(width);
                        if (right == '0) begin
                            out_quotient  <= '1;
                            out_remainder <= left;
                        end
                    end
                end
                BUSY: begin
                    dvd   <= {dvd[width-2:0], q_bit};
                    rem   <= rem_step;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        out_quotient  <= q_final;
                        out_remainder <= r_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_std_div_seq.sv
// Directed + randomized bench for std_div_seq at widths 8 and 32 against an arithmetic model.
module tb_std_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        go8, go32;
    logic [7:0]  l8, r8, q8, rm8;
    logic        d8;
    logic [31:0] l32, r32, q32, rm32;
    logic        d32;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    std_div_seq #(.width(8)) dut8 (
        .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
        .out_quotient(q8), .out_remainder(rm8), .done(d8)
    );

    std_div_seq #(.width(32)) dut32 (
        .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
        .out_quotient(q32), .out_remainder(rm32), .done(d32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = a & mask;
        b = b & mask;
        if (b == 0) begin
            q = mask;
            r = a;
        end else begin
`ifdef STD_DIV_SIGNED_EN
            sa = $signed(a << (64 - w)) >>> (64 - w);
            sb = $signed(b << (64 - w)) >>> (64 - w);
            if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
                q = a;
                r = 0;
            end else begin
                q = 64'(sa / sb) & mask;
                r = 64'(sa % sb) & mask;
            end
`else
            sa = 0;
            sb = 0;
            q  = a / b;
            r  = a % b;
`endif
        end
    endfunction

    task automatic do_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                         input bit toggle, input string tag);
        int unsigned w;
        logic [63:0] eq, er, hq, hr;
        int lat;
        w = wide ? 32 : 8;
        model(w, a, b, eq, er);
        @(negedge clk);
        if (wide) begin l32 = a[31:0]; r32 = b[31:0]; go32 = 1'b1; end
        else      begin l8  = a[7:0];  r8  = b[7:0];  go8  = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        if (wide) go32 = 1'b0; else go8 = 1'b0;
        lat = 1;
        while (!(wide ? d32 : d8) && lat < 200) begin
            // operands are free to change once the op has been accepted
            if (wide) begin
                l32 = $urandom; r32 = $urandom;
                if (toggle) go32 = 1'($urandom);
            end else begin
                l8 = 8'($urandom); r8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (wide) go32 = 1'b0;
        check({tag, "/latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'(w + 1));
        hq = wide ? 64'(q32) : 64'(q8);
        hr = wide ? 64'(rm32) : 64'(rm8);
        check({tag, "/quotient"}, hq, eq);
        check({tag, "/remainder"}, hr, er);
        @(negedge clk);
        check({tag, "/done_pulse"}, 64'(wide ? d32 : d8), 64'd0);
        check({tag, "/hold_q"}, wide ? 64'(q32) : 64'(q8), eq);
        check({tag, "/hold_r"}, wide ? 64'(rm32) : 64'(rm8), er);
    endtask

    initial begin
        logic [63:0] eq, er, a, b;
        int prev, pulses;
        bit  saw_done;

        reset = 1'b1; go8 = 1'b0; go32 = 1'b0;
        l8 = '0; r8 = '0; l32 = '0; r32 = '0;
        repeat (3) @(negedge clk);
        check("rst/q8", 64'(q8), 64'd0);
        check("rst/r8", 64'(rm8), 64'd0);
        check("rst/done8", 64'(d8), 64'd0);
        check("rst/q32", 64'(q32), 64'd0);
        check("rst/done32", 64'(d32), 64'd0);
        reset = 1'b0;

        do_op(1'b0, 100, 7, 1'b0, "100/7");
        do_op(1'b0, 200, 0, 1'b0, "200/0");
        do_op(1'b0, 0, 5, 1'b0, "0/5");
        do_op(1'b0, 201, 1, 1'b0, "201/1");
        do_op(1'b0, 5, 9, 1'b0, "5/9");
        do_op(1'b0, 255, 200, 1'b0, "255/200");
        do_op(1'b0, 8'hF9, 2, 1'b0, "-7/2");
        do_op(1'b0, 7, 8'hFE, 1'b0, "7/-2");
        do_op(1'b0, 8'h80, 8'hFF, 1'b0, "min/-1");

        // go held high: back-to-back ops every width+2 cycles
        @(negedge clk);
        l8 = 255; r8 = 1; go8 = 1'b1;
        model(8, 255, 1, eq, er);
        prev = -1; pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (d8) begin
                pulses++;
                check("held/q", 64'(q8), eq);
                check("held/r", 64'(rm8), er);
                if (prev >= 0) check("held/interval", 64'(i - prev), 64'd10);
                prev = i;
            end
        end
        check("held/pulses", 64'(pulses), 64'd3);
        go8 = 1'b0;
        repeat (12) @(negedge clk);
        do_op(1'b0, 0, 5, 1'b0, "after_held_0/5");

        // reset in the middle of BUSY abandons the op; go during reset is ignored
        @(negedge clk);
        l8 = 50; r8 = 3; go8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; go8 = 1'b1;
        @(negedge clk);
        reset = 1'b0; go8 = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (d8) saw_done = 1'b1;
            @(negedge clk);
        end
        check("midrst/no_done", 64'(saw_done), 64'd0);
        check("midrst/q", 64'(q8), 64'd0);
        check("midrst/r", 64'(rm8), 64'd0);
        do_op(1'b0, 9, 4, 1'b0, "9/4");

        do_op(1'b1, 64'hFFFF_FFFF, 64'h0001_0000, 1'b1, "w32_toggle");
        do_op(1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, "w32_big");
        do_op(1'b1, 12345, 0, 1'b0, "w32_div0");

        for (int i = 0; i < 20; i++) begin
            a = 64'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 255) >> $urandom_range(0, 7));
            do_op(1'b0, a, b, 1'b0, $sformatf("rnd8_%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            a = 64'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom >> $urandom_range(0, 31));
            do_op(1'b1, a, b, 1'b1, $sformatf("rnd32_%0d", i));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
